// File: rtl/rx_mac_writer.sv
// ============================================================================
// rx_mac_writer
// ----------------------------------------------------------------------------
// Purpose:
//   Packs frames arriving from a 64-bit MAC receive interface into a ring
//   buffer of 2^AW qwords. Each frame occupies one header qword at start
//   address S followed by its payload qwords at S+1, S+2, ... (mod 2^AW).
//   The header is {byte_count[31:0], frames_received_before_commit[31:0]}
//   and is written only after the frame ends good. At that point the
//   committed write pointer is advanced past the frame.
//   One ring slot is always left empty so that a full ring can be told
//   apart from an empty one. Frames that end bad, overflow MAX_QW qwords or
//   run into uncommitted-consumer space are dropped without touching the
//   committed pointer.
//
// Parameters:
//   AW      ring address width in qwords (2^AW entries)
//   MAX_QW  largest accepted payload in qwords; longer frames are dropped
//
// Ports:
//   clk                      in   sole clock, rising edge
//   reset                    in   asynchronous active-high reset
//   rx_data[63:0]            in   MAC data, byte 0 in [7:0]
//   rx_data_valid[7:0]       in   contiguous byte enables from bit 0
//   rx_good_frame            in   pulse: frame ended OK
//   rx_bad_frame             in   pulse: frame ended with error
//   wr_addr[AW-1:0]          out  memory write address (registered)
//   wr_data[63:0]            out  memory write data (registered)
//   wr_en                    out  memory write strobe (registered)
//   commited_rd_addr[AW-1:0] in   consumer's released address
//   commited_wr_addr[AW-1:0] out  first address after last committed frame
//   commited_wr_addr_change  out  pulse when commited_wr_addr updates
//   frames_received[31:0]    out  saturating count of committed frames
//   frames_dropped[31:0]     out  saturating count of dropped frames
// ============================================================================
module rx_mac_writer #(
    parameter int AW     = 9,
    parameter int MAX_QW = 1200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   rx_data,
    input  logic [7:0]    rx_data_valid,
    input  logic          rx_good_frame,
    input  logic          rx_bad_frame,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          wr_en,
    input  logic [AW-1:0] commited_rd_addr,
    output logic [AW-1:0] commited_wr_addr,
    output logic          commited_wr_addr_change,
    output logic [31:0]   frames_received,
    output logic [31:0]   frames_dropped
);

    // Wide enough to hold MAX_QW+1 so the overflow comparison never wraps.
    localparam int QW_W = $clog2(MAX_QW + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_HDR,
        S_DROP
    } state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_start, w_start_next;
    logic [QW_W-1:0] r_qw, w_qw_next;
    logic [31:0]     r_bytes, w_bytes_next;
    logic [AW-1:0]   r_wr_addr, w_wr_addr_next;
    logic [63:0]     r_wr_data, w_wr_data_next;
    logic            r_wr_en, w_wr_en_next;
    logic [AW-1:0]   r_commit, w_commit_next;
    logic            r_chg, w_chg_next;
    logic [31:0]     r_frx, w_frx_next;
    logic [31:0]     r_fdrop, w_fdrop_next;

    // Frame context seen by the data path. In IDLE a new frame is implicitly
    // starting at the committed pointer with zero counts, so the first word
    // can be processed in the same cycle it arrives.
    logic [AW-1:0]   w_base;
    logic [QW_W-1:0] w_qw_cur;
    logic [31:0]     w_bytes_cur;
    logic [AW-1:0]   w_target;
    logic [3:0]      w_pop;
    logic [31:0]     w_frx_inc;
    logic [31:0]     w_fdrop_inc;

    // Address a may be written unless the slot after it is where the
    // consumer currently stands (keeps one slot permanently empty).
    function automatic logic f_writable(input logic [AW-1:0] a,
                                        input logic [AW-1:0] rd);
        return (a + AW'(1)) != rd;
    endfunction

    assign w_base      = (r_state == S_IDLE) ? r_commit : r_start;
    assign w_qw_cur    = (r_state == S_IDLE) ? '0 : r_qw;
    assign w_bytes_cur = (r_state == S_IDLE) ? '0 : r_bytes;
    assign w_target    = w_base + AW'(1) + AW'(w_qw_cur);
    assign w_frx_inc   = (r_frx == 32'hFFFF_FFFF) ? r_frx : r_frx + 32'd1;
    assign w_fdrop_inc = (r_fdrop == 32'hFFFF_FFFF) ? r_fdrop : r_fdrop + 32'd1;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'b000, rx_data_valid[i]};
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_start_next   = r_start;
        w_qw_next      = r_qw;
        w_bytes_next   = r_bytes;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_commit_next  = r_commit;
        w_chg_next     = 1'b0;
        w_frx_next     = r_frx;
        w_fdrop_next   = r_fdrop;

        case (r_state)
            S_IDLE, S_DATA: begin
                if (r_state == S_IDLE) begin
                    w_start_next = r_commit;
                    w_qw_next    = '0;
                    w_bytes_next = '0;
                end
                if (rx_data_valid != 8'h00) begin
                    w_state_next = S_DATA;
                    if (rx_bad_frame) begin
                        // Write suppressed: the frame is being discarded anyway.
                        w_fdrop_next = w_fdrop_inc;
                        w_state_next = S_IDLE;
                    end else if (!f_writable(w_target, commited_rd_addr) ||
                                 (32'(w_qw_cur) >= MAX_QW)) begin
                        // If the frame also ends now, there is nothing left to
                        // wait for in DROP, so account for it immediately.
                        if (rx_good_frame) begin
                            w_fdrop_next = w_fdrop_inc;
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next = S_DROP;
                        end
                    end else begin
                        w_wr_en_next   = 1'b1;
                        w_wr_addr_next = w_target;
                        w_wr_data_next = rx_data;
                        w_qw_next      = w_qw_cur + QW_W'(1);
                        w_bytes_next   = w_bytes_cur + 32'(w_pop);
                        if (rx_good_frame) begin
                            w_state_next = S_HDR;
                        end
                    end
                end else if (r_state == S_DATA) begin
                    if (rx_bad_frame) begin
                        w_fdrop_next = w_fdrop_inc;
                        w_state_next = S_IDLE;
                    end else if (rx_good_frame) begin
                        w_state_next = S_HDR;
                    end
                end
            end

            S_HDR: begin
                if (f_writable(r_start, commited_rd_addr)) begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = r_start;
                    w_wr_data_next = {r_bytes, r_frx};
                    w_commit_next  = r_start + AW'(1) + AW'(r_qw);
                    w_chg_next     = 1'b1;
                    w_frx_next     = w_frx_inc;
                end else begin
                    w_fdrop_next = w_fdrop_inc;
                end
                w_state_next = S_IDLE;
            end

            S_DROP: begin
                if (rx_good_frame || rx_bad_frame) begin
                    w_fdrop_next = w_fdrop_inc;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start   <= '0;
            r_qw      <= '0;
            r_bytes   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_commit  <= '0;
            r_chg     <= 1'b0;
            r_frx     <= '0;
            r_fdrop   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_start   <= w_start_next;
            r_qw      <= w_qw_next;
            r_bytes   <= w_bytes_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
            r_commit  <= w_commit_next;
            r_chg     <= w_chg_next;
            r_frx     <= w_frx_next;
            r_fdrop   <= w_fdrop_next;
        end
    end

    assign wr_en                   = r_wr_en;
    assign wr_addr                 = r_wr_addr;
    assign wr_data                 = r_wr_data;
    assign commited_wr_addr        = r_commit;
    assign commited_wr_addr_change = r_chg;
    assign frames_received         = r_frx;
    assign frames_dropped          = r_fdrop;

endmodule

// File: tb/tb_rx_mac_writer.sv
// ============================================================================
// tb_rx_mac_writer
// ----------------------------------------------------------------------------
// Directed bench for rx_mac_writer. Instance A uses default parameters;
// instance B uses AW=4, MAX_QW=13 to reach ring wrap and the length limit
// with short frames. Memory writes are captured into per-instance arrays.
// ============================================================================
module tb_rx_mac_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A (AW=9)
    logic [63:0] a_data;
    logic [7:0]  a_valid;
    logic        a_good, a_bad;
    logic [8:0]  a_rd;
    logic [8:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_wr_en;
    logic [8:0]  a_commit;
    logic        a_chg;
    logic [31:0] a_frx, a_fdrop;

    // Instance B (AW=4, MAX_QW=13)
    logic [63:0] b_data;
    logic [7:0]  b_valid;
    logic        b_good, b_bad;
    logic [3:0]  b_rd;
    logic [3:0]  b_wr_addr;
    logic [63:0] b_wr_data;
    logic        b_wr_en;
    logic [3:0]  b_commit;
    logic        b_chg;
    logic [31:0] b_frx, b_fdrop;

    rx_mac_writer #(.AW(9), .MAX_QW(1200)) dut_a (
        .clk(clk), .reset(rst),
        .rx_data(a_data), .rx_data_valid(a_valid),
        .rx_good_frame(a_good), .rx_bad_frame(a_bad),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_en(a_wr_en),
        .commited_rd_addr(a_rd), .commited_wr_addr(a_commit),
        .commited_wr_addr_change(a_chg),
        .frames_received(a_frx), .frames_dropped(a_fdrop)
    );

    rx_mac_writer #(.AW(4), .MAX_QW(13)) dut_b (
        .clk(clk), .reset(rst),
        .rx_data(b_data), .rx_data_valid(b_valid),
        .rx_good_frame(b_good), .rx_bad_frame(b_bad),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_en(b_wr_en),
        .commited_rd_addr(b_rd), .commited_wr_addr(b_commit),
        .commited_wr_addr_change(b_chg),
        .frames_received(b_frx), .frames_dropped(b_fdrop)
    );

    int checks   = 0;
    int failures = 0;

    // Write capture, sampled on the falling edge
    logic [63:0] mem_a [0:511];
    logic [63:0] mem_b [0:15];
    int          wcnt_a = 0, wcnt_b = 0, chg_a = 0, chg_b = 0;
    logic [8:0]  last_a = '0;
    logic [3:0]  last_b = '0;

    always @(negedge clk) begin
        if (a_wr_en === 1'b1) begin
            mem_a[a_wr_addr] <= a_wr_data;
            wcnt_a           <= wcnt_a + 1;
            last_a           <= a_wr_addr;
        end
        if (a_chg === 1'b1) chg_a <= chg_a + 1;
        if (b_wr_en === 1'b1) begin
            mem_b[b_wr_addr] <= b_wr_data;
            wcnt_b           <= wcnt_b + 1;
            last_b           <= b_wr_addr;
        end
        if (b_chg === 1'b1) chg_b <= chg_b + 1;
    end

    function automatic logic [63:0] pat(input int id, input int k);
        return {8'hDA, 24'(id), 32'(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word_a(input logic [63:0] d, input logic [7:0] v,
                          input logic g, input logic b);
        a_data = d; a_valid = v; a_good = g; a_bad = b;
        tick();
        a_data = '0; a_valid = '0; a_good = 1'b0; a_bad = 1'b0;
    endtask

    task automatic word_b(input logic [63:0] d, input logic [7:0] v,
                          input logic g, input logic b);
        b_data = d; b_valid = v; b_good = g; b_bad = b;
        tick();
        b_data = '0; b_valid = '0; b_good = 1'b0; b_bad = 1'b0;
    endtask

    // Good frame of n words; the last word carries last_v and the good pulse.
    task automatic frame_a(input int n, input logic [7:0] last_v, input int id);
        for (int k = 0; k < n; k++)
            word_a(pat(id, k), (k == n - 1) ? last_v : 8'hFF, k == n - 1, 1'b0);
        repeat (4) tick();
    endtask

    task automatic frame_b(input int n, input logic [7:0] last_v, input int id);
        for (int k = 0; k < n; k++)
            word_b(pat(id, k), (k == n - 1) ? last_v : 8'hFF, k == n - 1, 1'b0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_data = '0; a_valid = '0; a_good = 1'b0; a_bad = 1'b0; a_rd = '0;
        b_data = '0; b_valid = '0; b_good = 1'b0; b_bad = 1'b0; b_rd = '0;
        repeat (3) tick();
        checks++;
        if ({a_wr_en, a_wr_addr, a_chg} !== 11'd0) begin
            failures++;
            $display("FAIL reset_ctrl: wr_en=%b wr_addr=%0d chg=%b, expected 0/0/0", a_wr_en, a_wr_addr, a_chg);
        end
        checks++;
        if (a_wr_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_wr_data: got %h expected 0", a_wr_data);
        end
        checks++;
        if ({a_commit, b_commit} !== 13'd0) begin
            failures++;
            $display("FAIL reset_commit: a=%0d b=%0d expected 0", a_commit, b_commit);
        end
        checks++;
        if ({a_frx, a_fdrop} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counters: rx=%0d drop=%0d expected 0/0", a_frx, a_fdrop);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_64byte();
        int c0, w0;
        c0 = chg_a; w0 = wcnt_a;
        frame_a(8, 8'hFF, 1);
        checks++;
        if (mem_a[0] !== {32'd64, 32'd0}) begin
            failures++;
            $display("FAIL f64_header: got %h expected %h", mem_a[0], {32'd64, 32'd0});
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (mem_a[k] !== pat(1, k - 1)) begin
                failures++;
                $display("FAIL f64_data[%0d]: got %h expected %h", k, mem_a[k], pat(1, k - 1));
            end
        end
        checks++;
        if (a_commit !== 9'd9) begin
            failures++;
            $display("FAIL f64_commit: got %0d expected 9", a_commit);
        end
        checks++;
        if (chg_a - c0 != 1) begin
            failures++;
            $display("FAIL f64_chg_pulses: got %0d expected 1", chg_a - c0);
        end
        checks++;
        if (a_frx !== 32'd1 || wcnt_a - w0 != 9) begin
            failures++;
            $display("FAIL f64_rx_writes: rx=%0d writes=%0d expected 1/9", a_frx, wcnt_a - w0);
        end
        $display("test_64byte done: commit=%0d rx=%0d", a_commit, a_frx);
    endtask

    task automatic test_61byte();
        frame_a(8, 8'h1F, 2);
        checks++;
        if (mem_a[9] !== {32'd61, 32'd1}) begin
            failures++;
            $display("FAIL f61_header: got %h expected %h", mem_a[9], {32'd61, 32'd1});
        end
        checks++;
        if (mem_a[17] !== pat(2, 7)) begin
            failures++;
            $display("FAIL f61_last_data: got %h expected %h", mem_a[17], pat(2, 7));
        end
        checks++;
        if (a_commit !== 9'd18 || a_frx !== 32'd2) begin
            failures++;
            $display("FAIL f61_commit_rx: commit=%0d rx=%0d expected 18/2", a_commit, a_frx);
        end
        $display("test_61byte done: commit=%0d", a_commit);
    endtask

    task automatic test_bad_frame();
        int c0;
        c0 = chg_a;
        for (int k = 0; k < 5; k++) word_a(pat(3, k), 8'hFF, 1'b0, 1'b0);
        word_a(64'd0, 8'h00, 1'b0, 1'b1);
        repeat (4) tick();
        checks++;
        if (a_commit !== 9'd18 || chg_a != c0) begin
            failures++;
            $display("FAIL bad_commit: commit=%0d pulses=%0d expected 18/0", a_commit, chg_a - c0);
        end
        checks++;
        if (a_fdrop !== 32'd1) begin
            failures++;
            $display("FAIL bad_dropped: got %0d expected 1", a_fdrop);
        end
        frame_a(2, 8'hFF, 4);
        checks++;
        if (mem_a[18] !== {32'd16, 32'd2} || mem_a[19] !== pat(4, 0)) begin
            failures++;
            $display("FAIL bad_reuse: hdr=%h data=%h expected %h/%h", mem_a[18], mem_a[19], {32'd16, 32'd2}, pat(4, 0));
        end
        checks++;
        if (a_commit !== 9'd21 || a_frx !== 32'd3) begin
            failures++;
            $display("FAIL bad_next_commit: commit=%0d rx=%0d expected 21/3", a_commit, a_frx);
        end
        $display("test_bad_frame done: dropped=%0d commit=%0d", a_fdrop, a_commit);
    endtask

    task automatic test_reset_midframe();
        a_data = pat(5, 0); a_valid = 8'hFF;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_wr_en, a_wr_addr} !== 10'd0 || a_wr_data !== 64'd0) begin
            failures++;
            $display("FAIL async_reset_wr: wr_en=%b addr=%0d data=%h expected 0", a_wr_en, a_wr_addr, a_wr_data);
        end
        checks++;
        if (a_commit !== 9'd0 || a_frx !== 32'd0 || a_fdrop !== 32'd0) begin
            failures++;
            $display("FAIL async_reset_state: commit=%0d rx=%0d drop=%0d expected 0", a_commit, a_frx, a_fdrop);
        end
        a_data = '0; a_valid = '0;
        tick();
        rst = 1'b0;
        tick();
        frame_a(2, 8'hFF, 6);
        checks++;
        if (mem_a[0] !== {32'd16, 32'd0}) begin
            failures++;
            $display("FAIL post_reset_header: got %h expected %h", mem_a[0], {32'd16, 32'd0});
        end
        checks++;
        if (a_commit !== 9'd3 || a_frx !== 32'd1 || a_fdrop !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_state: commit=%0d rx=%0d drop=%0d expected 3/1/0", a_commit, a_frx, a_fdrop);
        end
        $display("test_reset_midframe done: commit=%0d", a_commit);
    endtask

    task automatic test_full();
        int c0, w0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_rd = 9'd5;
        tick();
        c0 = chg_a; w0 = wcnt_a;
        frame_a(10, 8'hFF, 7);
        checks++;
        if (wcnt_a - w0 != 3 || last_a !== 9'd3) begin
            failures++;
            $display("FAIL full_writes: count=%0d last=%0d expected 3/3", wcnt_a - w0, last_a);
        end
        checks++;
        if (mem_a[3] !== pat(7, 2)) begin
            failures++;
            $display("FAIL full_data3: got %h expected %h", mem_a[3], pat(7, 2));
        end
        checks++;
        if (a_fdrop !== 32'd1 || a_commit !== 9'd0 || chg_a != c0 || a_frx !== 32'd0) begin
            failures++;
            $display("FAIL full_state: drop=%0d commit=%0d pulses=%0d rx=%0d expected 1/0/0/0", a_fdrop, a_commit, chg_a - c0, a_frx);
        end
        $display("test_full done: dropped=%0d", a_fdrop);
    endtask

    task automatic test_wrap();
        b_rd = 4'd0;
        frame_b(13, 8'hFF, 8);
        checks++;
        if (b_commit !== 4'd14 || mem_b[0] !== {32'd104, 32'd0}) begin
            failures++;
            $display("FAIL wrap_setup: commit=%0d hdr=%h expected 14/%h", b_commit, mem_b[0], {32'd104, 32'd0});
        end
        b_rd = 4'd10;
        frame_b(3, 8'hFF, 9);
        checks++;
        if (mem_b[14] !== {32'd24, 32'd1}) begin
            failures++;
            $display("FAIL wrap_header: got %h expected %h", mem_b[14], {32'd24, 32'd1});
        end
        checks++;
        if (mem_b[15] !== pat(9, 0) || mem_b[0] !== pat(9, 1) || mem_b[1] !== pat(9, 2)) begin
            failures++;
            $display("FAIL wrap_data: 15=%h 0=%h 1=%h", mem_b[15], mem_b[0], mem_b[1]);
        end
        checks++;
        if (b_commit !== 4'd2 || b_frx !== 32'd2) begin
            failures++;
            $display("FAIL wrap_commit: commit=%0d rx=%0d expected 2/2", b_commit, b_frx);
        end
        $display("test_wrap done: commit=%0d", b_commit);
    endtask

    task automatic test_max_qw();
        int w0;
        b_rd = 4'd2;
        w0 = wcnt_b;
        frame_b(14, 8'hFF, 10);
        checks++;
        if (wcnt_b - w0 != 13 || last_b !== 4'd15) begin
            failures++;
            $display("FAIL maxqw_writes: count=%0d last=%0d expected 13/15", wcnt_b - w0, last_b);
        end
        checks++;
        if (b_fdrop !== 32'd1 || b_commit !== 4'd2 || b_frx !== 32'd2) begin
            failures++;
            $display("FAIL maxqw_state: drop=%0d commit=%0d rx=%0d expected 1/2/2", b_fdrop, b_commit, b_frx);
        end
        $display("test_max_qw done: dropped=%0d", b_fdrop);
    endtask

    initial begin
        test_reset();
        test_64byte();
        test_61byte();
        test_bad_frame();
        test_reset_midframe();
        test_full();
        test_wrap();
        test_max_qw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_mac_writer.md
RX_MAC_WRITER -- requirements
Module: rx_mac_writer

Interface
REQ-001 SHALL have parameter AW, default 9, meaning ring buffer address width in qwords (2^AW entries).
REQ-002 SHALL have parameter MAX_QW, default 1200, meaning max payload qwords per frame; longer frames are dropped.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  in  64  MAC receive data, byte 0 in [7:0].
REQ-006 SHALL have port rx_data_valid  in  8  byte enables, contiguous from bit 0 (FF, 7F .. 01, 00).
REQ-007 SHALL have port rx_good_frame  in  1  one-cycle pulse: current frame ended OK.
REQ-008 SHALL have port rx_bad_frame  in  1  one-cycle pulse: current frame ended with error.
REQ-009 SHALL have port wr_addr  out  AW  memory write address.
REQ-010 SHALL have port wr_data  out  64  memory write data.
REQ-011 SHALL have port wr_en  out  1  memory write strobe.
REQ-012 SHALL have port commited_rd_addr  in  AW  consumer's released address, same clock domain.
REQ-013 SHALL have port commited_wr_addr  out  AW  first address after last committed frame.
REQ-014 SHALL have port commited_wr_addr_change  out  1  one-cycle pulse when commited_wr_addr updates.
REQ-015 SHALL have ports frames_received and frames_dropped  out  32 each  saturating counters.

Function
REQ-016 SHALL store each frame as one header qword at start address S followed by payload qwords at S+1.., addresses mod 2^AW.
REQ-017 SHALL format header as [63:32] = frame byte count, [31:0] = frames_received value before increment.
REQ-018 SHALL register all outputs; wr_en/wr_addr/wr_data appear one cycle after the input word that causes them.
REQ-019 SHALL treat address a as writable iff a+1 != commited_rd_addr (one slot always empty).
REQ-020 SHALL run FSM states IDLE, DATA, HDR, DROP; reset state IDLE.
REQ-021 IDLE: S = commited_wr_addr, byte/qword counters = 0; on rx_data_valid != 0 go DATA and process that word as DATA would.
REQ-022 DATA: each cycle with rx_data_valid != 0 writes rx_data to S+1+qword count, adds popcount(rx_data_valid) to byte count, increments qword count; cycles with valid = 0 write nothing.
REQ-023 DATA: if target address is not writable, or qword count would exceed MAX_QW, suppress the write and go DROP.
REQ-024 DATA: rx_good_frame in the same cycle as a valid word writes that word first, then goes HDR; rx_good_frame alone goes HDR.
REQ-025 DATA: rx_bad_frame (alone or with data) discards the frame: increment frames_dropped, go IDLE, commited_wr_addr unchanged.
REQ-026 HDR (one cycle): write header to S, set commited_wr_addr = S+1+qword count, pulse commited_wr_addr_change, increment frames_received, go IDLE.
REQ-027 HDR: if S itself is not writable, skip the header write and commit, increment frames_dropped, go IDLE.
REQ-028 DROP: ignore data; on rx_good_frame or rx_bad_frame increment frames_dropped and go IDLE.
REQ-029 Data arriving in HDR SHALL be ignored; the MAC guarantees an inter-frame gap of at least 2 cycles.
REQ-030 SHALL never write an address outside [S, S+1+MAX_QW] for the current frame, and never modify committed data.
REQ-031 Counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-032 On reset, within the same cycle, asynchronously: wr_en = 0, wr_addr = 0, wr_data = 0, commited_wr_addr = 0, commited_wr_addr_change = 0, both counters = 0, FSM = IDLE.
REQ-033 Reset mid-frame SHALL abandon the frame with no commit; the first frame after release starts at address 0.

Verification
REQ-034 Empty buffer, 64-byte frame (8 words of FF), then good -> header at 0 = {32'd64, 32'd0}, data at 1..8, commited_wr_addr = 9, one change pulse, frames_received = 1.
REQ-035 61-byte frame (7×FF + 8'h1F) -> header byte count 61, 8 payload qwords, commited_wr_addr advances by 9.
REQ-036 Bad frame after 5 words -> commited_wr_addr unchanged, no change pulse, frames_dropped = 1; next good frame overwrites the same start address.
REQ-037 commited_rd_addr = 5, commited_wr_addr = 0, 10-word frame -> writes stop at address 3, DROP entered, frames_dropped = 1, commited_wr_addr stays 0.
REQ-038 AW = 4, commited_wr_addr = 14, commited_rd_addr = 10, 3-word frame -> header at 14, data at 15, 0, 1, commited_wr_addr = 2.
REQ-039 Reset asserted mid-frame, then a 16-byte good frame -> header at 0, commited_wr_addr = 3, counters restart at 0/1.
